sap_ram_loader: RTL
===================

Name: sap_ram_loader

Overview:
- Sequential writer/controller for the SAP 16-word program RAM, built from two 4-bit active-low-strobe RAM chips with inverted outputs, giving 8 bits per word.
- Accepts a 16-byte program stream over a valid/ready handshake.
- Writes each byte with a timed CS/WE strobe (setup, pulse, hold phases).
- Then reads every word back, re-inverts it, and compares it against a shadow copy, flagging the first mismatch.
- Sits between the front-panel/boot source and the RAM chip pair.

Parameters:
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W words.
- DATA_W, 8, word width (two 4-bit chips side by side).
- SETUP_CYC, 1, cycles with address/data/CS valid before WE falls (>=1).
- PULSE_CYC, 2, cycles WE is held low (>=1).
- HOLD_CYC, 1, cycles address/data/CS held after WE rises (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a load at address 0.
- in_valid  input  1  program byte valid.
- in_data  input  DATA_W  program byte.
- in_ready  output  1  loader accepts in_data this cycle when in_valid=1.
- ram_a  output  ADDR_W  RAM address, shared by both chips.
- ram_d  output  DATA_W  RAM write data; [7:4] feeds the high chip, [3:0] the low chip.
- ram_cs_n  output  1  chip select, active low, shared.
- ram_we_n  output  1  write enable, active low, shared.
- ram_o  input  DATA_W  RAM outputs; these are inverted data.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse at the end of verify.
- err  output  1  sticky verify mismatch flag; cleared on the next accepted start.
- err_addr  output  ADDR_W  address of the first mismatch; valid while err=1.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on rst_n; all state is cleared immediately on assertion.
- Reset values:
  - State = IDLE.
  - ram_cs_n=1, ram_we_n=1, ram_a=0, ram_d=0.
  - in_ready=0, busy=0, done=0, err=0, err_addr=0.
  - Shadow contents are don't-care.
- IDLE:
  - CS and WE are deasserted.
  - On start=1: addr<=0, err<=0, err_addr<=0, busy<=1, go to WAIT_DATA.
- WAIT_DATA:
  - in_ready=1 and CS deasserted.
  - On in_valid&&in_ready: latch in_data into ram_d and into shadow[addr], go to SETUP.
  - in_ready is a registered output and drops in the cycle after acceptance, so exactly one byte is taken per word.
- SETUP:
  - ram_cs_n=0, ram_we_n=1, ram_a=addr, ram_d stable.
  - Lasts SETUP_CYC cycles, then go to PULSE.
- PULSE:
  - ram_we_n=0; CS, address and data unchanged.
  - Lasts PULSE_CYC cycles, then go to HOLD.
- HOLD:
  - ram_we_n=1, CS still 0, address and data unchanged.
  - Lasts HOLD_CYC cycles.
  - Then, if addr==depth-1: addr<=0 and go to READ. Otherwise addr<=addr+1 and go to WAIT_DATA.
  - Address wrap happens only on this transition.
- Write strobe invariants:
  - ram_a and ram_d never change while ram_we_n=0.
  - ram_we_n never falls in the same cycle that ram_cs_n falls.
  - The minimum cycles per word is 1 + SETUP_CYC + PULSE_CYC + HOLD_CYC; with the defaults, 5 cycles from acceptance to the next in_ready.
- READ:
  - ram_cs_n=0, ram_we_n=1, ram_a=addr. One settle cycle, then go to CHECK.
- CHECK:
  - Compare ~ram_o against shadow[addr].
  - On mismatch with err==0: err<=1, err_addr<=addr. Later mismatches do not overwrite err_addr.
  - If addr==depth-1, go to DONE; otherwise addr<=addr+1 and go to READ.
- DONE:
  - done=1 for one cycle, busy<=0, CS deasserted, return to IDLE.
  - err and err_addr hold their values.
- Corner cases:
  - start while busy: ignored.
  - in_valid outside WAIT_DATA: ignored, and no byte is consumed.
  - in_valid low indefinitely: the loader waits in WAIT_DATA with CS deasserted.
  - rst_n asserted mid-strobe: ram_we_n and ram_cs_n go high asynchronously. The RAM word at the current address is undefined; no recovery is attempted.
- Timing: total latency for a full load with back-to-back data is 16×5 + 16×2 + 1 = 113 cycles from start to done.
- Counters: phase counter width is clog2 of max(SETUP_CYC, PULSE_CYC, HOLD_CYC)+1. Address counter width is ADDR_W and never exceeds depth-1.

Decomposition:
- Shared package sap_pkg:
  - State enum ldr_state_t = {IDLE, WAIT_DATA, SETUP, PULSE, HOLD, READ, CHECK, DONE}.
  - Constants RAM_ADDR_W=4 and RAM_DATA_W=8.
- One sub-module, ldr_strobe_timer: loadable down-counter that emits a one-cycle expiry for the SETUP/PULSE/HOLD phase lengths.
- The shadow store is an inline register array.

Test Plan:
- Reset mid-PULSE (rst_n low in the cycle after ram_we_n falls) -> ram_we_n=1 and ram_cs_n=1 the same cycle without a clock edge; busy=0; err=0.
- start, then stream 0x00..0x0F back-to-back against two behavioural 16x4 inverted-output RAMs:
  - exactly 16 WE pulses, each 2 cycles low;
  - ram_a/ram_d stable across each pulse;
  - done at cycle 113 after start;
  - err=0;
  - RAM holds mem[i]=i.
- Same stream with in_valid dropped for 7 cycles before byte 5 -> CS stays high during the gap; byte 5 written to address 5; done at cycle 120.
- Fault model: the high-chip bit at address 0xA is forced to 0 and data 0xFF is written everywhere -> err=1, err_addr=0xA at done. A second forced fault at 0xC leaves err_addr=0xA.
- start pulsed again during verify -> ignored (no restart, done still at 113). A start after done clears err, and the reload completes with err=0.
- in_valid held high continuously with changing data -> one byte is consumed per word only. Accepted bytes match the in_ready&&in_valid cycles, and 16 handshakes occur in total.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP program-RAM loader: RAM geometry and the
// loader state encoding.
package sap_pkg;

    localparam int RAM_ADDR_W = 4;
    localparam int RAM_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        SETUP,
        PULSE,
        HOLD,
        READ,
        CHECK,
        DONE
    } ldr_state_t;

endpackage

// File: rtl/ldr_strobe_timer.sv
// Loadable down-counter that times the SETUP/PULSE/HOLD phases of a RAM
// write strobe. expire pulses for exactly one cycle when a loaded count
// reaches zero; a load value of N gives an expiry N+1 cycles after the load.
module ldr_strobe_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;
    logic             armed;

    assign expire = armed && (cnt == '0);

    // Count down from the loaded value; disarm once the expiry has fired
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (load) begin
            cnt   <= load_val;
            armed <= 1'b1;
        end else if (expire) begin
            armed <= 1'b0;
        end else if (cnt != '0) begin
            cnt   <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/sap_ram_loader.sv
// Sequential writer for the SAP 16-word program RAM (two 4-bit chips with
// inverted outputs). Takes one byte per word over valid/ready, writes it with
// a timed CS/WE strobe, then reads every word back and flags the first
// address whose re-inverted contents differ from the shadow copy.
module sap_ram_loader
    import sap_pkg::*;
#(
    parameter int ADDR_W    = RAM_ADDR_W,
    parameter int DATA_W    = RAM_DATA_W,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_cs_n,
    output logic              ram_we_n,
    input  logic [DATA_W-1:0] ram_o,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    ldr_state_t        state, next_state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] shadow [2**ADDR_W];

    logic              cs_n_nxt, we_n_nxt, ready_nxt, done_nxt;
    logic              tmr_load, tmr_expire;
    logic [CNT_W-1:0]  tmr_val;
    logic              accept, last_addr, mismatch;

    assign accept    = (state == WAIT_DATA) && in_valid && in_ready;
    assign last_addr = (addr == {ADDR_W{1'b1}});
    assign mismatch  = ((~ram_o) != shadow[addr]);
    assign ram_a     = addr;

    ldr_strobe_timer #(
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    // Reload the phase timer whenever a strobe phase is entered
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (next_state != state) begin
            case (next_state)
                SETUP: begin
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(SETUP_CYC - 1);
                end
                PULSE: begin
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(PULSE_CYC - 1);
                end
                HOLD: begin
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(HOLD_CYC - 1);
                end
                default: ;
            endcase
        end
    end

    // Next-state sequencing: write pass over all words, then verify pass
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (start)      next_state = WAIT_DATA;
            WAIT_DATA: if (accept)     next_state = SETUP;
            SETUP:     if (tmr_expire) next_state = PULSE;
            PULSE:     if (tmr_expire) next_state = HOLD;
            HOLD:      if (tmr_expire) next_state = last_addr ? READ : WAIT_DATA;
            READ:                      next_state = CHECK;
            CHECK:                     next_state = last_addr ? DONE : READ;
            DONE:                      next_state = IDLE;
            default:                   next_state = IDLE;
        endcase
    end

    // Strobe and handshake levels decoded from the upcoming state so the
    // registered pins switch together with the state itself
    always_comb begin
        cs_n_nxt  = 1'b1;
        we_n_nxt  = 1'b1;
        ready_nxt = 1'b0;
        done_nxt  = 1'b0;
        case (next_state)
            WAIT_DATA:               ready_nxt = 1'b1;
            SETUP, HOLD, READ, CHECK: cs_n_nxt = 1'b0;
            PULSE: begin
                cs_n_nxt = 1'b0;
                we_n_nxt = 1'b0;
            end
            DONE:                    done_nxt  = 1'b1;
            default: ;
        endcase
    end

    // State register with glitch-free registered strobe/handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ram_cs_n <= 1'b1;
            ram_we_n <= 1'b1;
            in_ready <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= next_state;
            ram_cs_n <= cs_n_nxt;
            ram_we_n <= we_n_nxt;
            in_ready <= ready_nxt;
            done     <= done_nxt;
        end
    end

    // Address walk, write-data latch, busy and first-mismatch capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            ram_d    <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
            err_addr <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    addr     <= '0;
                    err      <= 1'b0;
                    err_addr <= '0;
                    busy     <= 1'b1;
                end
                WAIT_DATA: if (accept) ram_d <= in_data;
                HOLD: if (tmr_expire) addr <= last_addr ? '0 : addr + 1'b1;
                CHECK: begin
                    if (mismatch && !err) begin
                        err      <= 1'b1;
                        err_addr <= addr;
                    end
                    if (!last_addr) addr <= addr + 1'b1;
                end
                DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

    // Shadow copy of each accepted byte for the verify pass
    always_ff @(posedge clk) begin
        if (accept) shadow[addr] <= in_data;
    end

endmodule
